std_pipe_reg: RTL and testbench
===============================

STD_PIPE_REG -- requirements
Module: std_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port in  input  WIDTH  data to enter stage 0.
REQ-007 Port write_en  input  1  in is valid this cycle.
REQ-008 Port stall  input  1  hold all stages; input ignored.
REQ-009 Port flush  input  1  invalidate all stages.
REQ-010 Port out  output  WIDTH  data of final stage (DEPTH-1).
REQ-011 Port out_valid  output  1  final stage holds a valid datum (level).
REQ-012 Port done  output  1  one-cycle pulse when a valid datum first arrives in the final stage.
REQ-013 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH.

Function
REQ-014 The block SHALL hold DEPTH stages, each a WIDTH-bit data register plus a valid bit.
REQ-015 With stall=0 and flush=0, on each edge stage i valid SHALL take stage i-1 valid, and stage 0 valid SHALL take write_en.
REQ-016 A stage data register SHALL load only when its incoming valid is 1; otherwise it holds its value (bubbles do not overwrite data).
REQ-017 Latency SHALL be exactly DEPTH cycles: write_en sampled at edge t makes out/out_valid show that datum after edge t+DEPTH-1, and done high in that same cycle, absent stalls.
REQ-018 With stall=1 and flush=0, all data, valid bits and occupancy SHALL hold; write_en and in SHALL be ignored (producer retries).
REQ-019 done SHALL be 1 only in the cycle after an edge where final-stage valid was loaded with 1 by a shift; done SHALL be 0 during any stalled cycle after that.
REQ-020 flush=1 SHALL clear all valid bits, occupancy and done at the next edge, overriding stall and write_en (write that cycle discarded); data registers SHALL hold.
REQ-021 occupancy SHALL update incrementally: unstalled next = occ + write_en - final-stage valid; stalled next = occ; flush next = 0; never exceeds DEPTH.
REQ-022 out and out_valid SHALL be driven directly from final-stage registers (no combinational path from inputs).
REQ-023 DEPTH=1 SHALL behave as a plain enabled register: out holds the last written value indefinitely; done pulses one cycle per write.
REQ-024 Back-to-back write_en every cycle SHALL sustain one datum per cycle with no bubbles.

Reset
REQ-025 On reset_n low, asynchronously: all stage data = RESET_VAL, all valid = 0, out = RESET_VAL, out_valid = 0, done = 0, occupancy = 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight data; first edge after release behaves as an unstalled empty pipe.

Structure
REQ-027 Package std_pipe_pkg SHALL hold the occupancy-width helper function and a shared stage-control enum (SHIFT, HOLD, CLEAR).
REQ-028 One sub-module std_pipe_stage (data + valid, inputs: d, v_in, ctrl) SHALL be instantiated DEPTH times via generate.

Verification
REQ-029 WIDTH=8, DEPTH=4: write 0x11,0x22,0x33 on consecutive cycles -> out 0x11,0x22,0x33 with done high 4,5,6 cycles after first write; occupancy peaks 3.
REQ-030 DEPTH=4: write 0xA5, stall=1 for 3 cycles starting 2 cycles later -> done arrives 7 cycles after write, single pulse, out=0xA5 held after.
REQ-031 DEPTH=4, pipe holding 3 valid, flush with write_en=1 same cycle -> next cycle occupancy=0, out_valid=0, no done ever for any of those 4 data.
REQ-032 DEPTH=1: write 0x5C, then idle 10 cycles -> out=0x5C throughout, done high exactly 1 cycle, occupancy 1 then 0.
REQ-033 DEPTH=4, 4 data in flight, reset_n low between edges -> outputs reset immediately (RESET_VAL, 0, 0, 0); after release with no writes, done never asserts.
REQ-034 Random write_en/stall/flush 10k cycles, DEPTH in {1,3,8} -> out sequence matches scoreboard FIFO model; occupancy equals model count every cycle.

Source files
------------

// File: rtl/std_pipe_pkg.sv
// Shared types and helpers for the std_pipe_reg pipeline slice.
package std_pipe_pkg;

    // Per-edge action applied uniformly to every stage of the pipe.
    typedef enum logic [1:0] {
        SHIFT = 2'b00,
        HOLD  = 2'b01,
        CLEAR = 2'b10
    } stage_ctrl_e;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Flush wins over stall; a plain cycle shifts.
    function automatic stage_ctrl_e stage_ctrl(input logic stall, input logic flush);
        if (flush) begin
            return CLEAR;
        end
        if (stall) begin
            return HOLD;
        end
        return SHIFT;
    endfunction

endpackage

// File: rtl/std_pipe_reg_stage.sv
// One pipeline stage: a data register plus its valid bit.
module std_pipe_stage
    import std_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             v_in,
    input  stage_ctrl_e      ctrl,
    output logic [WIDTH-1:0] q,
    output logic             v_out
);

    // Valid bit follows the upstream valid on a shift, drops on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_out <= 1'b0;
        end else begin
            case (ctrl)
                SHIFT:   v_out <= v_in;
                CLEAR:   v_out <= 1'b0;
                default: v_out <= v_out;
            endcase
        end
    end

    // Data only captures real data; bubbles and clears leave it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else if (ctrl == SHIFT && v_in) begin
            q <= d;
        end
    end

endmodule

// File: rtl/std_pipe_reg.sv
// Stallable, flushable DEPTH-stage register pipe with occupancy tracking.
module std_pipe_reg
    import std_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [WIDTH-1:0]                in,
    input  logic                            write_en,
    input  logic                            stall,
    input  logic                            flush,
    output logic [WIDTH-1:0]                out,
    output logic                            out_valid,
    output logic                            done,
    output logic [occ_width(DEPTH)-1:0]     occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    stage_ctrl_e        ctrl;
    logic [WIDTH-1:0]   chain_d [DEPTH+1];
    logic               chain_v [DEPTH+1];
    logic [OCC_W-1:0]   occ_next;

    // One control word shared by all stages.
    always_comb begin
        ctrl = stage_ctrl(stall, flush);
    end

    // Element 0 of the chain is the producer, element DEPTH the final stage.
    assign chain_d[0] = in;
    assign chain_v[0] = write_en;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        std_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (chain_d[i]),
            .v_in    (chain_v[i]),
            .ctrl    (ctrl),
            .q       (chain_d[i+1]),
            .v_out   (chain_v[i+1])
        );
    end

    assign out       = chain_d[DEPTH];
    assign out_valid = chain_v[DEPTH];

    // Pulse when the final stage is loaded with a valid datum by a shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= (ctrl == SHIFT) && chain_v[DEPTH-1];
        end
    end

    // Incremental count: one in from the producer, one out of the final stage.
    always_comb begin
        occ_next = occupancy;
        case (ctrl)
            SHIFT:   occ_next = occupancy + OCC_W'(write_en) - OCC_W'(out_valid);
            CLEAR:   occ_next = '0;
            default: occ_next = occupancy;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule

// File: tb/tb_std_pipe_reg.sv
// Self-checking bench for std_pipe_reg: four depths driven in lockstep,
// compared against an age-based scoreboard of in-flight data.
module tb_std_pipe_reg;

    logic       clk;
    logic       reset_n;
    logic [7:0] in;
    logic       write_en;
    logic       stall;
    logic       flush;

    logic [7:0] out4, out1, out3, out8;
    logic       ov4, ov1, ov3, ov8;
    logic       done4, done1, done3, done8;
    logic [2:0] occ4;
    logic [0:0] occ1;
    logic [1:0] occ3;
    logic [3:0] occ8;

    int checks = 0;
    int errors = 0;

    std_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
        .clk(clk), .reset_n(reset_n), .in(in), .write_en(write_en), .stall(stall),
        .flush(flush), .out(out4), .out_valid(ov4), .done(done4), .occupancy(occ4));
    std_pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .reset_n(reset_n), .in(in), .write_en(write_en), .stall(stall),
        .flush(flush), .out(out1), .out_valid(ov1), .done(done1), .occupancy(occ1));
    std_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h3C)) dut3 (
        .clk(clk), .reset_n(reset_n), .in(in), .write_en(write_en), .stall(stall),
        .flush(flush), .out(out3), .out_valid(ov3), .done(done3), .occupancy(occ3));
    std_pipe_reg #(.WIDTH(8), .DEPTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .reset_n(reset_n), .in(in), .write_en(write_en), .stall(stall),
        .flush(flush), .out(out8), .out_valid(ov8), .done(done8), .occupancy(occ8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs gathered by DUT index.
    logic [7:0]  o_out  [4];
    logic        o_ov   [4];
    logic        o_done [4];
    int unsigned o_occ  [4];
    assign o_out[0] = out4;  assign o_ov[0] = ov4;  assign o_done[0] = done4;  assign o_occ[0] = int'(occ4);
    assign o_out[1] = out1;  assign o_ov[1] = ov1;  assign o_done[1] = done1;  assign o_occ[1] = int'(occ1);
    assign o_out[2] = out3;  assign o_ov[2] = ov3;  assign o_done[2] = done3;  assign o_occ[2] = int'(occ3);
    assign o_out[3] = out8;  assign o_ov[3] = ov8;  assign o_done[3] = done8;  assign o_occ[3] = int'(occ8);

    // Reference: each in-flight datum carries its age (edges since entry).
    // Oldest first; a datum sits in the final stage at age dep-1 and leaves at dep.
    int         dep [4] = '{4, 1, 3, 8};
    logic [7:0] rv  [4] = '{8'h00, 8'h00, 8'h3C, 8'h00};
    logic [7:0] e_d   [4][8];
    int         e_age [4][8];
    int         e_n   [4];
    logic [7:0] m_out [4];
    logic       m_done[4];

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            e_n[k]    = 0;
            m_done[k] = 1'b0;
            m_out[k]  = rv[k];
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            if (flush) begin
                e_n[k]    = 0;
                m_done[k] = 1'b0;
            end else if (stall) begin
                m_done[k] = 1'b0;
            end else begin
                for (int j = 0; j < e_n[k]; j++) e_age[k][j]++;
                if (e_n[k] > 0 && e_age[k][0] >= dep[k]) begin
                    for (int j = 1; j < e_n[k]; j++) begin
                        e_d[k][j-1]   = e_d[k][j];
                        e_age[k][j-1] = e_age[k][j];
                    end
                    e_n[k]--;
                end
                if (write_en) begin
                    e_d[k][e_n[k]]   = in;
                    e_age[k][e_n[k]] = 0;
                    e_n[k]++;
                end
                m_done[k] = (e_n[k] > 0 && e_age[k][0] == dep[k] - 1);
                if (m_done[k]) m_out[k] = e_d[k][0];
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("d%0d_out", dep[k]),  o_out[k],  m_out[k]);
            check($sformatf("d%0d_valid", dep[k]), o_ov[k],
                  (e_n[k] > 0 && e_age[k][0] == dep[k] - 1));
            check($sformatf("d%0d_done", dep[k]), o_done[k], m_done[k]);
            check($sformatf("d%0d_occ", dep[k]),  o_occ[k],  e_n[k]);
        end
    endtask

    // Inputs change only at the falling edge, so the model sees what the DUT sampled.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        write_en = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (n) cycle();
    endtask

    logic [7:0]  w3 [3] = '{8'h11, 8'h22, 8'h33};
    int unsigned peak;

    initial begin
        reset_n  = 1'b0;
        in       = '0;
        write_en = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out4", out4, 8'h00);
        check("rst_out3", out3, 8'h3C);
        check("rst_valid4", ov4, 0);
        check("rst_done4", done4, 0);
        check("rst_occ4", occ4, 0);
        compare_all();
        reset_n = 1'b1;

        // Three back-to-back writes through the depth-4 pipe.
        idle(2);
        peak = 0;
        for (int c = 0; c < 9; c++) begin
            write_en = (c < 3);
            if (c < 3) in = w3[c];
            cycle();
            check("seq_done", done4, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) check("seq_out", out4, w3[c-3]);
            if (occ4 > peak) peak = occ4;
        end
        check("seq_peak", peak, 3);

        // Single write with a three-cycle stall mid-flight.
        idle(6);
        for (int c = 0; c < 11; c++) begin
            write_en = (c == 0);
            in       = 8'hA5;
            stall    = (c >= 2 && c <= 4);
            cycle();
            check("stall_done", done4, (c == 6));
            if (c >= 6) check("stall_out", out4, 8'hA5);
        end
        stall = 1'b0;

        // Flush with a concurrent write while three data are in flight.
        idle(10);
        for (int c = 0; c < 12; c++) begin
            write_en = (c <= 3);
            in       = 8'($urandom);
            flush    = (c == 3);
            cycle();
            check("flush_done", done4, 0);
            if (c == 2) check("flush_pre_occ", occ4, 3);
            if (c >= 3) begin
                check("flush_occ", occ4, 0);
                check("flush_valid", ov4, 0);
            end
        end
        flush = 1'b0;

        // Depth-1 pipe behaves as an enabled register.
        idle(10);
        for (int c = 0; c < 11; c++) begin
            write_en = (c == 0);
            in       = 8'h5C;
            cycle();
            check("d1_hold", out1, 8'h5C);
            check("d1_pulse", done1, (c == 0));
            check("d1_occ", occ1, (c == 0));
        end

        // Asynchronous reset with a full depth-4 pipe.
        idle(10);
        for (int c = 0; c < 4; c++) begin
            write_en = 1'b1;
            in       = 8'($urandom);
            cycle();
        end
        write_en = 1'b0;
        check("full_occ", occ4, 4);
        check("full_valid", ov4, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_out4", out4, 8'h00);
        check("arst_valid4", ov4, 0);
        check("arst_done4", done4, 0);
        check("arst_occ4", occ4, 0);
        check("arst_out3", out3, 8'h3C);
        model_reset();
        compare_all();
        #1 reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("post_rst_done", done4, 0);
            check("post_rst_valid", ov4, 0);
        end

        // Random traffic on all depths at once.
        for (int c = 0; c < 10000; c++) begin
            write_en = ($urandom_range(0, 99) < 60);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 4);
            in       = 8'($urandom);
            cycle();
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
